// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock controller.
// Provides the FSM state encoding (visible on the controller's state port),
// player index constants and winner codes.
package chess_clock_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_RUN_P1 = 3'd2,
    S_RUN_P2 = 3'd3,
    S_PAUSE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Player indices into the two-bit per-timer vectors.
  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/tick_divider.sv
// Decrement-strobe divider for the chess clock.
// Counts 0..DIV-1 while run is high and emits tick for one cycle at DIV-1,
// wrapping to 0. The count is held while run is low; restart forces it to 0
// and takes priority over counting.
// Ports:
//   clk, nrst  clock, asynchronous active-low reset
//   run        count enable (a player's clock is running)
//   restart    synchronous clear of the count
//   tick       one-cycle strobe when the count is at DIV-1 and run is high
module tick_divider #(
  parameter int unsigned DIV = 10_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick    = run && (count_q == LAST);
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (run) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/chess_clock_ctrl.sv
// Two-player game-clock sequencer driving two countdown timers
// (index 0 = P1, index 1 = P2).
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   start_pb         IDLE->SETUP, SETUP->RUN_P1, PAUSE->resume
//   pause_pb         RUN->PAUSE, PAUSE->resume
//   p1_pb, p2_pb     active player ends own turn
//   add_pb           +30 lap to both timers while in SETUP
//   clear_pb         abort to IDLE from SETUP, PAUSE, DONE
//   time_up[1:0]     sticky timeout flags from the timers
//   tick             decrement strobe to both timers
//   en_dec[1:0]      per-timer decrement enable (one-hot or zero)
//   en_in[1:0]       per-timer load enable (SETUP)
//   lap[1:0]         registered +30 pulse
//   clr[1:0]         registered clear pulse, issued in the first IDLE cycle
//   state[2:0]       current FSM state
//   winner[1:0]      01 P1 won, 10 P2 won, 00 none
module chess_clock_ctrl #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start_pb,
  input  logic       pause_pb,
  input  logic       p1_pb,
  input  logic       p2_pb,
  input  logic       add_pb,
  input  logic       clear_pb,
  input  logic [1:0] time_up,
  output logic       tick,
  output logic [1:0] en_dec,
  output logic [1:0] en_in,
  output logic [1:0] lap,
  output logic [1:0] clr,
  output logic [2:0] state,
  output logic [1:0] winner
);

  import chess_clock_pkg::*;

  state_t     state_q, state_d;
  logic       saved_turn_q, saved_turn_d;
  logic [1:0] winner_q, winner_d;
  logic [1:0] lap_q, lap_d;
  logic [1:0] clr_q, clr_d;

  logic div_run;
  logic div_restart;

  always_comb begin
    state_d      = state_q;
    saved_turn_d = saved_turn_q;
    winner_d     = winner_q;
    lap_d        = '0;
    clr_d        = '0;
    case (state_q)
      S_IDLE: begin
        if (start_pb) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (clear_pb) begin
          state_d = S_IDLE;
          clr_d   = '1;
        end else if (start_pb) begin
          state_d = S_RUN_P1;
        end else if (add_pb) begin
          lap_d = '1;
        end
      end
      S_RUN_P1: begin
        if (time_up[P1]) begin
          state_d  = S_DONE;
          winner_d = WIN_P2;
        end else if (pause_pb) begin
          state_d      = S_PAUSE;
          saved_turn_d = P1;
        end else if (p1_pb) begin
          state_d = S_RUN_P2;
        end
      end
      S_RUN_P2: begin
        if (time_up[P2]) begin
          state_d  = S_DONE;
          winner_d = WIN_P1;
        end else if (pause_pb) begin
          state_d      = S_PAUSE;
          saved_turn_d = P2;
        end else if (p2_pb) begin
          state_d = S_RUN_P1;
        end
      end
      S_PAUSE: begin
        if (clear_pb) begin
          state_d = S_IDLE;
          clr_d   = '1;
        end else if (start_pb || pause_pb) begin
          state_d = (saved_turn_q == P2) ? S_RUN_P2 : S_RUN_P1;
        end
      end
      S_DONE: begin
        if (clear_pb) begin
          state_d  = S_IDLE;
          clr_d    = '1;
          winner_d = WIN_NONE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        winner_d = WIN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      saved_turn_q <= P1;
      winner_q     <= WIN_NONE;
      lap_q        <= '0;
      clr_q        <= '0;
    end else begin
      state_q      <= state_d;
      saved_turn_q <= saved_turn_d;
      winner_q     <= winner_d;
      lap_q        <= lap_d;
      clr_q        <= clr_d;
    end
  end

  // The divider counts in either RUN state; PAUSE holds it so a resumed turn
  // keeps its partial second. A turn hand-over or entry to IDLE/SETUP/DONE
  // starts the next second from zero.
  assign div_run     = (state_q == S_RUN_P1) || (state_q == S_RUN_P2);
  assign div_restart = (state_d == S_IDLE) || (state_d == S_SETUP) || (state_d == S_DONE) ||
                       ((state_q == S_RUN_P1) && (state_d == S_RUN_P2)) ||
                       ((state_q == S_RUN_P2) && (state_d == S_RUN_P1));

  tick_divider #(
    .DIV (TICK_DIV)
  ) u_tick_divider (
    .clk     (clk),
    .nrst    (nrst),
    .run     (div_run),
    .restart (div_restart),
    .tick    (tick)
  );

  assign en_dec = (state_q == S_RUN_P1) ? 2'b01 :
                  (state_q == S_RUN_P2) ? 2'b10 : 2'b00;
  assign en_in  = (state_q == S_SETUP) ? 2'b11 : 2'b00;
  assign lap    = lap_q;
  assign clr    = clr_q;
  assign state  = state_q;
  assign winner = winner_q;

endmodule
